input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Front-end stage that sits upstream of the mode-select/state logic in the PWM lab top level.
- Synchronizes and debounces the raw slide switches and push button.
- Decodes the clean switch code into a one-hot mode vector: linear, sine, servo, mood.
- Emits single-cycle event pulses, so downstream mode registers and effect units never see metastable, bouncing or transient intermediate codes.

Parameters:
- NUM_SW, 4, width of the switch vector.
- SYNC_STAGES, 2, flip-flop stages in each synchronizer chain (>=2).
- DEBOUNCE_CYCLES, 1_250_000, consecutive stable cycles required to accept a new level (10 ms at 125 MHz, >=1). Counter width is clog2(DEBOUNCE_CYCLES+1).

Ports:
- clk  input  1  system clock, 125 MHz.
- rst  input  1  asynchronous, active-high reset.
- sw_raw  input  NUM_SW  raw switch pins, asynchronous.
- btn_raw  input  1  raw push-button pin, asynchronous.
- sw_clean  output  NUM_SW  debounced switch vector.
- mode_onehot  output  4  decoded mode: bit0 = code 1, bit1 = code 2, bit2 = code 3, bit3 = code 4.
- mode_change  output  1  one-cycle pulse when sw_clean takes a new value.
- btn_level  output  1  debounced button level.
- btn_press  output  1  one-cycle pulse on debounced rising edge.
- btn_release  output  1  one-cycle pulse on debounced falling edge.

Behaviour:
- Reset: all synchronizer flops, counters and outputs are 0. Reset is asynchronous, active-high, on clk domain.
- Synchronizers: each raw bit passes through a SYNC_STAGES flop chain. Only the final stage (sync value) is used downstream.
- Switch debounce, whole-vector:
  - One counter sw_cnt.
  - If sync vector == sw_clean: sw_cnt <= 0.
  - Else if sync vector differs from its value on the previous cycle: sw_cnt <= 0, because any change restarts the count.
  - Else if sw_cnt == DEBOUNCE_CYCLES-1: sw_clean <= sync vector, sw_cnt <= 0.
  - Else: sw_cnt <= sw_cnt+1.
  - Consequence: a multi-bit transition never exposes an intermediate code on sw_clean.
- Button debounce: independent counter with identical rules applied to the 1-bit sync value, updating btn_level.
- Latency: a clean step on a raw input appears on the output SYNC_STAGES + DEBOUNCE_CYCLES cycles after the first clk edge that samples it.
- mode_onehot: registered and updated on the same edge as sw_clean, from the accepted value.
  - 1 -> 0001, 2 -> 0010, 3 -> 0100, 4 -> 1000.
  - Any other code, including 0, -> 0000.
- mode_change: high for exactly the first cycle sw_clean shows a newly accepted value. Accepting always implies a difference, so no pulse is possible without a change.
- btn_press / btn_release: high for exactly the first cycle btn_level shows 1 / 0 after a transition. They are never both high, and never high for more than one cycle per transition.
- Simultaneous switch and button acceptance on the same edge: both event pulses assert in the same cycle. The two paths are independent.
- DEBOUNCE_CYCLES = 1: a new value is accepted after one cycle of disagreement at the sync output.
- Counter saturation cannot occur; the count is bounded by DEBOUNCE_CYCLES-1.
- Reset mid-count: counters clear and partially counted changes are discarded.
- After rst deasserts with raw inputs held high:
  - The full latency elapses, then sw_clean updates and mode_change pulses.
  - btn_press pulses, because the reset level is 0.
- No output glitches: all outputs are driven directly from flops.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=8 for simulation):
- Reset released, sw_raw 0 -> 3 held -> sw_clean=3 and mode_onehot=0100 exactly 10 cycles after the change; mode_change high for that single cycle; outputs unchanged before it.
- sw_raw toggles 0/1 every 3 cycles for 30 cycles, then holds 1 -> sw_clean stays 0 throughout the bounce; becomes 1 exactly 10 cycles after the final edge; one mode_change pulse.
- sw_raw 1 -> 3 for 4 cycles -> 2 held -> sw_clean never equals 3; mode_onehot goes 0001 -> 0010 directly, with one mode_change pulse.
- btn_raw high for 20 cycles then low -> btn_press pulse at cycle 10; btn_level high for 20 cycles; btn_release pulse 10 cycles after the falling edge.
- sw_raw=5 held -> sw_clean=5, mode_onehot=0000, one mode_change pulse.
- sw_raw 0 -> 4, rst asserted at count 5 for 3 cycles -> all outputs 0 immediately; after release, sw_clean=4 and mode_onehot=1000 a full 10 cycles later, with no earlier acceptance.

Source files
------------

// File: rtl/input_conditioner.sv
// Synchronizes and debounces slide switches and push button, decodes the
// accepted switch code into a one-hot mode vector and emits event pulses.
module input_conditioner #(
  parameter int NUM_SW          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_250_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] sw_raw,
  input  logic              btn_raw,
  output logic [NUM_SW-1:0] sw_clean,
  output logic [3:0]        mode_onehot,
  output logic              mode_change,
  output logic              btn_level,
  output logic              btn_press,
  output logic              btn_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Button rides in the top bit so one chain covers every raw pin.
  logic [SYNC_STAGES-1:0][NUM_SW:0] sync_q;

  logic [NUM_SW-1:0] sw_sync;
  logic              btn_sync;

  logic [NUM_SW-1:0] sw_prev_q;
  logic [CW-1:0]     sw_cnt_q, sw_cnt_d;
  logic [NUM_SW-1:0] sw_clean_q;
  logic [3:0]        mode_q;
  logic              mode_chg_q;
  logic              sw_accept;

  logic              btn_prev_q;
  logic [CW-1:0]     btn_cnt_q, btn_cnt_d;
  logic              btn_level_q;
  logic              btn_press_q;
  logic              btn_rel_q;
  logic              btn_accept;

  function automatic logic [3:0] decode(input logic [NUM_SW-1:0] code);
    logic [31:0] cw;
    logic [3:0]  oh;
    cw = 32'(code);
    oh = 4'b0000;
    case (cw)
      32'd1:   oh = 4'b0001;
      32'd2:   oh = 4'b0010;
      32'd3:   oh = 4'b0100;
      32'd4:   oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= {btn_raw, sw_raw};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sw_sync  = sync_q[SYNC_STAGES-1][NUM_SW-1:0];
  assign btn_sync = sync_q[SYNC_STAGES-1][NUM_SW];

  // Whole-vector count: any bit moving restarts, so no partial code escapes.
  always_comb begin
    sw_cnt_d  = '0;
    sw_accept = 1'b0;
    if (sw_sync == sw_clean_q) begin
      sw_cnt_d = '0;
    end else if (sw_sync != sw_prev_q) begin
      sw_cnt_d = '0;
    end else if (sw_cnt_q == CNT_MAX) begin
      sw_accept = 1'b1;
    end else begin
      sw_cnt_d = sw_cnt_q + 1'b1;
    end
  end

  always_comb begin
    btn_cnt_d  = '0;
    btn_accept = 1'b0;
    if (btn_sync == btn_level_q) begin
      btn_cnt_d = '0;
    end else if (btn_sync != btn_prev_q) begin
      btn_cnt_d = '0;
    end else if (btn_cnt_q == CNT_MAX) begin
      btn_accept = 1'b1;
    end else begin
      btn_cnt_d = btn_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_prev_q  <= '0;
      sw_cnt_q   <= '0;
      sw_clean_q <= '0;
      mode_q     <= '0;
      mode_chg_q <= 1'b0;
    end else begin
      sw_prev_q  <= sw_sync;
      sw_cnt_q   <= sw_cnt_d;
      mode_chg_q <= sw_accept;
      if (sw_accept) begin
        sw_clean_q <= sw_sync;
        mode_q     <= decode(sw_sync);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev_q  <= 1'b0;
      btn_cnt_q   <= '0;
      btn_level_q <= 1'b0;
      btn_press_q <= 1'b0;
      btn_rel_q   <= 1'b0;
    end else begin
      btn_prev_q  <= btn_sync;
      btn_cnt_q   <= btn_cnt_d;
      btn_press_q <= btn_accept & btn_sync;
      btn_rel_q   <= btn_accept & ~btn_sync;
      if (btn_accept) begin
        btn_level_q <= btn_sync;
      end
    end
  end

  assign sw_clean    = sw_clean_q;
  assign mode_onehot = mode_q;
  assign mode_change = mode_chg_q;
  assign btn_level   = btn_level_q;
  assign btn_press   = btn_press_q;
  assign btn_release = btn_rel_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Randomized and directed checks of input_conditioner against a
// run-length reference model of the sync + debounce behaviour.
module tb_input_conditioner;

  localparam int NSW = 4;
  localparam int S   = 2;
  localparam int D   = 8;
  localparam int LAT = S + D;
  // Edges counted from the one that first samples the new raw level.
  localparam int FIRST = LAT + 1;
  localparam int FIRST_D1 = S + 1 + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [NSW-1:0] sw_raw;
  logic           btn_raw;

  logic [NSW-1:0] sw_clean;
  logic [3:0]     mode_onehot;
  logic           mode_change, btn_level, btn_press, btn_release;

  logic [NSW-1:0] d1_sw_clean;
  logic [3:0]     d1_mode_onehot;
  logic           d1_mode_change, d1_btn_level, d1_btn_press, d1_btn_release;

  input_conditioner #(
    .NUM_SW(NSW), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .btn_raw(btn_raw),
    .sw_clean(sw_clean), .mode_onehot(mode_onehot),
    .mode_change(mode_change), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release)
  );

  input_conditioner #(
    .NUM_SW(NSW), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(1)
  ) dut_d1 (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .btn_raw(btn_raw),
    .sw_clean(d1_sw_clean), .mode_onehot(d1_mode_onehot),
    .mode_change(d1_mode_change), .btn_level(d1_btn_level),
    .btn_press(d1_btn_press), .btn_release(d1_btn_release)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NSW-1:0] swq[$];
  logic           btnq[$];
  logic [NSW-1:0] sw_last, m_sw;
  logic           btn_last, m_btn;
  int             sw_run, btn_run;
  logic           m_chg, m_press, m_rel;

  logic [11:0] dut_vec;
  assign dut_vec = {sw_clean, mode_onehot, mode_change,
                    btn_level, btn_press, btn_release};

  function automatic logic [3:0] exp_onehot(input logic [NSW-1:0] c);
    case (c)
      4'd1:    return 4'b0001;
      4'd2:    return 4'b0010;
      4'd3:    return 4'b0100;
      4'd4:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [11:0] exp_vec();
    return {m_sw, exp_onehot(m_sw), m_chg, m_btn, m_press, m_rel};
  endfunction

  task automatic model_reset();
    swq = {};
    btnq = {};
    for (int i = 0; i < S; i++) begin
      swq.push_back('0);
      btnq.push_back(1'b0);
    end
    sw_last = '0; btn_last = 1'b0;
    sw_run = 0; btn_run = 0;
    m_sw = '0; m_btn = 1'b0;
    m_chg = 1'b0; m_press = 1'b0; m_rel = 1'b0;
  endtask

  // A level is accepted once the synchronized value has been seen on
  // D+1 consecutive edges while differing from the accepted value.
  task automatic tick();
    logic [NSW-1:0] s;
    logic           b;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      s = swq.pop_front();
      swq.push_back(sw_raw);
      b = btnq.pop_front();
      btnq.push_back(btn_raw);
      sw_run  = (s == sw_last) ? sw_run + 1 : 1;
      sw_last = s;
      btn_run  = (b == btn_last) ? btn_run + 1 : 1;
      btn_last = b;
      m_chg = 1'b0; m_press = 1'b0; m_rel = 1'b0;
      if (sw_run > D && s != m_sw) begin
        m_sw  = s;
        m_chg = 1'b1;
      end
      if (btn_run > D && b != m_btn) begin
        m_btn   = b;
        m_press = b;
        m_rel   = ~b;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sw_raw = '0;
    btn_raw = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (dut_vec !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", dut_vec, 12'h000);
    end
  endtask

  task automatic test_step();
    int first = -1;
    int nchg = 0;
    do_reset();
    sw_raw = 4'd3;
    for (int i = 1; i <= LAT + 5; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL step_cycle%0d: got %b expected %b", i, dut_vec, exp_vec());
      end
      if (sw_clean == 4'd3 && first < 0) first = i;
      if (mode_change) nchg++;
    end
    n_checks += 3;
    if (first != FIRST) begin
      n_fail++;
      $display("FAIL step_latency: got %0d expected %0d", first, FIRST);
    end
    if (nchg != 1) begin
      n_fail++;
      $display("FAIL step_pulses: got %0d expected 1", nchg);
    end
    if (mode_onehot !== 4'b0100) begin
      n_fail++;
      $display("FAIL step_onehot: got %b expected 0100", mode_onehot);
    end
  endtask

  task automatic test_bounce();
    int first = -1;
    int nchg = 0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      sw_raw = (k % 2 == 0) ? 4'd1 : 4'd0;
      for (int j = 0; j < 3; j++) begin
        tick();
        n_checks++;
        if (sw_clean !== 4'd0 || dut_vec !== exp_vec()) begin
          n_fail++;
          $display("FAIL bounce_hold: got %b expected %b", dut_vec, exp_vec());
        end
        if (mode_change) nchg++;
      end
    end
    sw_raw = 4'd1;
    for (int i = 1; i <= LAT + 5; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL bounce_cycle%0d: got %b expected %b", i, dut_vec, exp_vec());
      end
      if (sw_clean == 4'd1 && first < 0) first = i;
      if (mode_change) nchg++;
    end
    n_checks += 2;
    if (first != FIRST) begin
      n_fail++;
      $display("FAIL bounce_latency: got %0d expected %0d", first, FIRST);
    end
    if (nchg != 1) begin
      n_fail++;
      $display("FAIL bounce_pulses: got %0d expected 1", nchg);
    end
  endtask

  task automatic test_transient();
    int  nchg = 0;
    bit  seen3 = 0;
    bit  got_next = 0;
    logic [3:0] nxt = 4'b0000;
    do_reset();
    sw_raw = 4'd1;
    repeat (LAT + 3) tick();
    n_checks++;
    if (mode_onehot !== 4'b0001) begin
      n_fail++;
      $display("FAIL transient_start: got %b expected 0001", mode_onehot);
    end
    for (int i = 0; i < 4 + LAT + 5; i++) begin
      sw_raw = (i < 4) ? 4'd3 : 4'd2;
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL transient_cycle%0d: got %b expected %b", i, dut_vec, exp_vec());
      end
      if (sw_clean == 4'd3) seen3 = 1;
      if (mode_change) nchg++;
      if (!got_next && mode_onehot != 4'b0001) begin
        got_next = 1;
        nxt = mode_onehot;
      end
    end
    n_checks += 3;
    if (seen3) begin
      n_fail++;
      $display("FAIL transient_leak: got 1 expected 0");
    end
    if (nxt !== 4'b0010) begin
      n_fail++;
      $display("FAIL transient_next: got %b expected 0010", nxt);
    end
    if (nchg != 1) begin
      n_fail++;
      $display("FAIL transient_pulses: got %0d expected 1", nchg);
    end
  endtask

  task automatic test_button();
    int press_at = -1;
    int rel_at = -1;
    int lvl = 0;
    do_reset();
    btn_raw = 1'b1;
    for (int i = 1; i <= 20 + LAT + 5; i++) begin
      if (i == 21) btn_raw = 1'b0;
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL button_cycle%0d: got %b expected %b", i, dut_vec, exp_vec());
      end
      if (btn_press) press_at = i;
      if (btn_release) rel_at = i - 20;
      if (btn_level) lvl++;
    end
    n_checks += 3;
    if (press_at != FIRST) begin
      n_fail++;
      $display("FAIL button_press: got %0d expected %0d", press_at, FIRST);
    end
    if (rel_at != FIRST) begin
      n_fail++;
      $display("FAIL button_release: got %0d expected %0d", rel_at, FIRST);
    end
    if (lvl != 20) begin
      n_fail++;
      $display("FAIL button_level_len: got %0d expected 20", lvl);
    end
  endtask

  task automatic test_invalid_code();
    int nchg = 0;
    do_reset();
    sw_raw = 4'd5;
    for (int i = 1; i <= LAT + 5; i++) begin
      tick();
      if (mode_change) nchg++;
    end
    n_checks += 2;
    if ({sw_clean, mode_onehot} !== {4'd5, 4'b0000}) begin
      n_fail++;
      $display("FAIL invalid_code: got %h/%b expected 5/0000", sw_clean, mode_onehot);
    end
    if (nchg != 1) begin
      n_fail++;
      $display("FAIL invalid_pulses: got %0d expected 1", nchg);
    end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    do_reset();
    sw_raw = 4'd4;
    repeat (8) tick();
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got %b expected %b", dut_vec, 12'h000);
    end
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 1; i <= LAT + 5; i++) begin
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_mid_cycle%0d: got %b expected %b", i, dut_vec, exp_vec());
      end
      if (sw_clean != 4'd0 && first < 0) first = i;
    end
    n_checks += 2;
    if (first != FIRST) begin
      n_fail++;
      $display("FAIL reset_mid_latency: got %0d expected %0d", first, FIRST);
    end
    if (mode_onehot !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_mid_onehot: got %b expected 1000", mode_onehot);
    end
  endtask

  task automatic test_simultaneous();
    int chg_at = -1;
    int prs_at = -1;
    do_reset();
    sw_raw = 4'd2;
    btn_raw = 1'b1;
    for (int i = 1; i <= LAT + 3; i++) begin
      tick();
      if (mode_change) chg_at = i;
      if (btn_press) prs_at = i;
    end
    n_checks += 2;
    if (chg_at != FIRST) begin
      n_fail++;
      $display("FAIL simul_change: got %0d expected %0d", chg_at, FIRST);
    end
    if (prs_at != FIRST) begin
      n_fail++;
      $display("FAIL simul_press: got %0d expected %0d", prs_at, FIRST);
    end
  endtask

  task automatic test_debounce_one();
    int first = -1;
    do_reset();
    sw_raw = 4'd6;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (d1_sw_clean == 4'd6 && first < 0) first = i;
    end
    n_checks++;
    if (first != FIRST_D1) begin
      n_fail++;
      $display("FAIL d1_latency: got %0d expected %0d", first, FIRST_D1);
    end
  endtask

  task automatic test_random();
    int hold;
    do_reset();
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 1) == 1) sw_raw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) btn_raw = ~btn_raw;
      hold = (seg % 3 == 0) ? int'($urandom_range(D + 2, D + 14))
                            : int'($urandom_range(1, D + 3));
      for (int j = 0; j < hold; j++) begin
        tick();
        n_checks++;
        if (dut_vec !== exp_vec() || (btn_press && btn_release)) begin
          n_fail++;
          $display("FAIL random_seg%0d: got %b expected %b", seg, dut_vec, exp_vec());
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    sw_raw = '0;
    btn_raw = 1'b0;
    model_reset();
    test_reset();
    test_step();
    test_bounce();
    test_transient();
    test_button();
    test_invalid_code();
    test_reset_mid();
    test_simultaneous();
    test_debounce_one();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
